lii_stream_wrapper: RTL

Parametrised LII adapter between one physical LII channel per direction and an HLS kernel with multiple logical streams. The input side splits each addressed physical beat into NIN lanes, and each lane handshakes independently. The output side gathers one beat from each of NOUT lanes into a DEPTH-entry FIFO and emits it with a source/destination header. It sits between the LII fabric ports and the kernel, and generates the kernel clock-enable from output-buffer occupancy.

---
 rtl/lii_stream_wrapper.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/lii_stream_wrapper.sv
// LII adapter: one physical channel per direction to NIN/NOUT kernel lanes.
// Input beats fan out to lanes; output lanes gather into a FWFT FIFO.
module lii_stream_wrapper #(
    parameter int         NIN     = 2,
    parameter int         NOUT    = 2,
    parameter int         W       = 32,
    parameter int         PW      = 1024,
    parameter int         DEPTH   = 4,
    parameter logic [7:0] NODE_ID = 8'h00,
    parameter logic [7:0] DST_ID  = 8'h01
) (
    input  logic                aclk,
    input  logic                arstn,
    input  logic [PW-1:0]       lii_in_p0_tdata,
    input  logic                lii_in_p0_tvalid,
    output logic                lii_in_p0_tready,
    input  logic [7:0]          lii_in_p0_src,
    input  logic [7:0]          lii_in_p0_dst,
    output logic [PW-1:0]       lii_out_p0_tdata,
    output logic                lii_out_p0_tvalid,
    input  logic                lii_out_p0_tready,
    output logic [7:0]          lii_out_p0_src,
    output logic [7:0]          lii_out_p0_dst,
    output logic [NIN*W-1:0]    in_stream_tdata,
    output logic [NIN-1:0]      in_stream_tvalid,
    input  logic [NIN-1:0]      in_stream_tready,
    input  logic [NOUT*W-1:0]   out_stream_tdata,
    input  logic [NOUT-1:0]     out_stream_tvalid,
    output logic [NOUT-1:0]     out_stream_tready,
    output logic                ce,
    output logic [15:0]         drop_count
);

    localparam int IW = NIN * W;
    localparam int LW = NOUT * W;
    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_CE   = (AW+1)'(DEPTH - 2);

    // ---------------- input side ----------------
    logic [IW-1:0]  held;
    logic [NIN-1:0] pending;
    logic [NIN-1:0] in_hs;
    logic           in_accept;
    logic           in_match;

    assign in_hs            = pending & in_stream_tready;
    assign lii_in_p0_tready = (pending & ~in_hs) == '0;
    assign in_accept        = lii_in_p0_tvalid & lii_in_p0_tready;
    assign in_match         = lii_in_p0_dst == NODE_ID;
    assign in_stream_tvalid = pending;
    assign in_stream_tdata  = held;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            held    <= '0;
            pending <= '0;
        end else if (in_accept && in_match) begin
            held    <= lii_in_p0_tdata[IW-1:0];
            pending <= '1;
        end else begin
            pending <= pending & ~in_hs;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            drop_count <= '0;
        end else if (in_accept && !in_match && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end

    // ---------------- output capture ----------------
    logic [LW-1:0]   cap_data;
    logic [NOUT-1:0] cap;
    logic [NOUT-1:0] out_hs;
    logic [PW-1:0]   beat;

    assign out_stream_tready = ~cap;
    assign out_hs            = out_stream_tvalid & ~cap;

    always_comb begin
        beat         = '0;
        beat[LW-1:0] = cap_data;
    end

    // ---------------- FWFT FIFO ----------------
    logic [PW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          push;
    logic          pop;

    // Full is judged on registered count only: a same-cycle pop does not
    // make room for a push, which keeps the push path off the fabric ready.
    assign full = count == CNT_FULL;
    assign push = (&cap) && !full;
    assign pop  = (count != '0) && lii_out_p0_tready;

    assign lii_out_p0_tvalid = count != '0;
    assign lii_out_p0_tdata  = mem[rd_ptr[AW-1:0]];
    assign lii_out_p0_src    = NODE_ID;
    assign lii_out_p0_dst    = DST_ID;
    assign ce                = count <= CNT_CE;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            cap      <= '0;
            cap_data <= '0;
        end else begin
            if (push) begin
                cap <= '0;
            end else begin
                cap <= cap | out_hs;
            end
            for (int j = 0; j < NOUT; j++) begin
                if (out_hs[j]) begin
                    cap_data[j*W +: W] <= out_stream_tdata[j*W +: W];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + CNT_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + CNT_ONE;
            end
            unique case (1'b1)
                push && !pop: count <= count + CNT_ONE;
                pop && !push: count <= count - CNT_ONE;
                default:      count <= count;
            endcase
        end
    end

    // Storage needs no reset: only entries between the pointers are visible.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= beat;
        end
    end

    logic unused_src;
    assign unused_src = ^lii_in_p0_src;

    if (PW > IW) begin : g_in_pad
        logic unused_in_hi;
        assign unused_in_hi = ^lii_in_p0_tdata[PW-1:IW];
    end

endmodule
